// File: rtl/riscv_pkg.sv
// Shared RISC-V constants for the front end: opcodes, immediate format codes,
// the default bubble instruction and the IF/ID buffer state encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational RV32 field extraction, format classification and
// sign-extended immediate generation.
module instr_decode
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    fmt_e fmt_d;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
    assign fmt    = fmt_d;

    always_comb begin
        fmt_d   = FMT_R;
        illegal = 1'b0;
        case (instr[6:0])
            OP_OP:                                          fmt_d = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_MISC_MEM: fmt_d = FMT_I;
            OP_STORE:                                       fmt_d = FMT_S;
            OP_BRANCH:                                      fmt_d = FMT_B;
            OP_LUI, OP_AUIPC:                               fmt_d = FMT_U;
            OP_JAL:                                         fmt_d = FMT_J;
            default:                                        illegal = 1'b1;
        endcase
    end

    // Fill with the sign bit first, then overwrite the low bits; this works for any XLEN >= 32.
    always_comb begin
        imm = '0;
        if (!illegal) begin
            case (fmt_d)
                FMT_I: begin
                    imm        = {XLEN{instr[31]}};
                    imm[10:0]  = instr[30:20];
                end
                FMT_S: begin
                    imm        = {XLEN{instr[31]}};
                    imm[10:5]  = instr[30:25];
                    imm[4:0]   = instr[11:7];
                end
                FMT_B: begin
                    imm        = {XLEN{instr[31]}};
                    imm[11]    = instr[7];
                    imm[10:5]  = instr[30:25];
                    imm[4:1]   = instr[11:8];
                    imm[0]     = 1'b0;
                end
                FMT_U: begin
                    imm        = {XLEN{instr[31]}};
                    imm[30:12] = instr[30:12];
                    imm[11:0]  = 12'b0;
                end
                FMT_J: begin
                    imm        = {XLEN{instr[31]}};
                    imm[19:12] = instr[19:12];
                    imm[11]    = instr[20];
                    imm[10:1]  = instr[30:21];
                    imm[0]     = 1'b0;
                end
                default: imm = '0;
            endcase
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register built as a 2-entry skid buffer (main + skid) with
// registered in_ready, flush support and zero-latency decode of the head entry.
module if_id_pipe_reg
    import riscv_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter logic [31:0] RESET_INSTR = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal,
    output logic [1:0]      dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high on the same side; payload must stay stable while valid && !ready.

    pipe_state_e     state;
    logic [XLEN-1:0] main_pc;
    logic [31:0]     main_instr;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            in_xfer;
    logic            out_xfer;

    assign out_valid = (state != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign out_pc    = main_pc;
    assign out_instr = main_instr;
    assign dbg_state = state;

    // in_ready is computed from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state      <= ST_EMPTY;
            main_pc    <= '0;
            main_instr <= RESET_INSTR;
            skid_pc    <= '0;
            skid_instr <= RESET_INSTR;
            in_ready   <= rst_n;
        end else begin
            in_ready <= 1'b1;
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_pc    <= in_pc;
                        main_instr <= in_instr;
                        state      <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({in_xfer, out_xfer})
                        2'b10: begin
                            skid_pc    <= in_pc;
                            skid_instr <= in_instr;
                            state      <= ST_TWO;
                            in_ready   <= 1'b0;
                        end
                        2'b01: state <= ST_EMPTY;
                        2'b11: begin
                            main_pc    <= in_pc;
                            main_instr <= in_instr;
                        end
                        default: ;
                    endcase
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        main_pc    <= skid_pc;
                        main_instr <= skid_instr;
                        state      <= ST_ONE;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    instr_decode #(.XLEN(XLEN)) u_decode (
        .instr   (main_instr),
        .opcode  (opcode),
        .rs1     (rs1),
        .rs2     (rs2),
        .rd      (rd),
        .funct3  (funct3),
        .funct7  (funct7),
        .imm     (imm),
        .fmt     (fmt),
        .illegal (illegal)
    );

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: decode vector table, directed skid/flush/reset
// sequences and a randomized run against a queue-based reference model.
module tb_if_id_pipe_reg;
    import riscv_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_pc = '0;
    logic [31:0]     in_instr = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [1:0]      dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of {pc, instr}, capacity two.
    logic [63:0] exp_q[$];
    logic        ready_m = 1'b0;
    logic        idle_rst = 1'b1;

    typedef struct {
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        ill;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    if_id_pipe_reg #(.XLEN(XLEN), .RESET_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
        .funct3(funct3), .funct7(funct7), .imm(imm), .fmt(fmt),
        .illegal(illegal), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic dec_t ref_decode(input logic [31:0] i);
        dec_t d;
        logic [12:0] b;
        logic [20:0] j;
        d.fmt = 3'd0; d.imm = 32'd0; d.ill = 1'b0;
        b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        case (i[6:0])
            7'h33: d.fmt = 3'd0;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
                d.fmt = 3'd1; d.imm = 32'($signed(i[31:20]));
            end
            7'h23: begin d.fmt = 3'd2; d.imm = 32'($signed({i[31:25], i[11:7]})); end
            7'h63: begin d.fmt = 3'd3; d.imm = 32'($signed(b)); end
            7'h37, 7'h17: begin d.fmt = 3'd4; d.imm = i[31:12] * 32'd4096; end
            7'h6F: begin d.fmt = 3'd5; d.imm = 32'($signed(j)); end
            default: d.ill = 1'b1;
        endcase
        return d;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        dec_t d;
        check("in_ready", 64'(in_ready), 64'(ready_m));
        check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            d = ref_decode(exp_q[0][31:0]);
            check("out_pc", 64'(out_pc), 64'(exp_q[0][63:32]));
            check("out_instr", 64'(out_instr), 64'(exp_q[0][31:0]));
            check("fields", 64'({funct7, rs2, rs1, funct3, rd, opcode}), 64'(exp_q[0][31:0]));
            check("fmt", 64'(fmt), 64'(d.fmt));
            check("imm", 64'(imm), 64'(d.imm));
            check("illegal", 64'(illegal), 64'(d.ill));
        end else if (idle_rst) begin
            check("idle_instr", 64'(out_instr), 64'h13);
            check("idle_pc", 64'(out_pc), 64'h0);
            check("idle_opcode", 64'(opcode), 64'h13);
            check("idle_fmt", 64'(fmt), 64'd1);
            check("idle_imm", 64'(imm), 64'h0);
            check("idle_illegal", 64'(illegal), 64'h0);
        end
    endtask

    // Called at a falling edge: drive, take one rising edge, update the model, compare.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl);
        logic ix, ox;
        in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
        @(posedge clk);
        if (!rst_n) begin
            exp_q.delete(); ready_m = 1'b0; idle_rst = 1'b1;
        end else if (fl) begin
            exp_q.delete(); ready_m = 1'b1; idle_rst = 1'b1;
        end else begin
            ox = (exp_q.size() > 0) && ordy;
            ix = v && ready_m;
            if (ox) void'(exp_q.pop_front());
            if (ix) begin
                exp_q.push_back({pc, ins});
                idle_rst = 1'b0;
            end
            ready_m = (exp_q.size() < 2);
        end
        @(negedge clk);
        compare_all();
    endtask

    vec_t vecs[8];
    logic [6:0] ops[11] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
                            7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    initial begin
        logic [31:0] r;
        vecs[0] = '{32'hFE010EE3, 3'd3, 32'hFFFF_FFFC, 1'b0};
        vecs[1] = '{32'hFFF00093, 3'd1, 32'hFFFF_FFFF, 1'b0};
        vecs[2] = '{32'h000012B7, 3'd4, 32'h0000_1000, 1'b0};
        vecs[3] = '{32'h008000EF, 3'd5, 32'h0000_0008, 1'b0};
        vecs[4] = '{32'h0000007F, 3'd0, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'hFE112E23, 3'd2, 32'hFFFF_FFFC, 1'b0};
        vecs[6] = '{32'h002081B3, 3'd0, 32'h0000_0000, 1'b0};
        vecs[7] = '{32'hFFFFF297, 3'd4, 32'hFFFF_F000, 1'b0};

        // Reset: two edges low, then release.
        @(negedge clk);
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_out_instr", 64'(out_instr), 64'h13);
        check("rst_imm", 64'(imm), 64'h0);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        check("rel_in_ready", 64'(in_ready), 64'h1);

        // Streaming: back-to-back PCs 0, 4, 8 with out_ready high.
        for (int k = 0; k < 3; k++) begin
            step(1, 32'(4 * k), 32'h0000_0013 | (32'(k) << 7), 1, 0);
            check("stream_pc", 64'(out_pc), 64'(4 * k));
        end
        step(0, 0, 0, 1, 0);
        check("stream_drained", 64'(out_valid), 64'h0);

        // Stall and skid: three offered with out_ready low, two accepted.
        step(1, 32'h100, 32'h00100093, 0, 0);
        step(1, 32'h104, 32'h00200093, 0, 0);
        check("skid_in_ready", 64'(in_ready), 64'h0);
        step(1, 32'h108, 32'h00300093, 0, 0);
        check("skid_hold_pc", 64'(out_pc), 64'h100);
        step(0, 0, 0, 1, 0);
        check("skid_drain1", 64'(out_pc), 64'h104);
        step(0, 0, 0, 1, 0);
        check("skid_drain2", 64'(out_valid), 64'h0);

        // Flush in TWO while an input is offered.
        step(1, 32'h200, 32'h00500093, 0, 0);
        step(1, 32'h204, 32'h00600093, 0, 0);
        step(1, 32'h208, 32'h00700093, 0, 1);
        check("flush_valid", 64'(out_valid), 64'h0);
        check("flush_instr", 64'(out_instr), 64'h13);
        step(0, 0, 0, 1, 0);
        check("flush_dropped", 64'(out_valid), 64'h0);

        // Reset mid-operation from TWO.
        step(1, 32'h300, 32'h00800093, 0, 0);
        step(1, 32'h304, 32'h00900093, 0, 0);
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0);
        check("midrst_instr", 64'(out_instr), 64'h13);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0);

        // Decode vector table.
        foreach (vecs[k]) begin
            step(1, 32'(16 * k), vecs[k].instr, 1, 0);
            check("vec_fmt", 64'(fmt), 64'(vecs[k].fmt));
            check("vec_imm", 64'(imm), 64'(vecs[k].imm));
            check("vec_illegal", 64'(illegal), 64'(vecs[k].ill));
        end
        step(0, 0, 0, 1, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            r = $urandom;
            if ($urandom_range(0, 9) < 8) r[6:0] = ops[$urandom_range(0, 10)];
            rst_n = ($urandom_range(0, 99) != 0);
            step($urandom_range(0, 9) < 7, $urandom, r,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_pipe_reg.md
IF_ID_PIPE_REG -- requirements
Module: if_id_pipe_reg

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the PC width and the immediate width.
REQ-002 SHALL have parameter RESET_INSTR, default 32'h0000_0013 (NOP), meaning the instruction held after reset and after flush.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the IF stage presents an instruction.
REQ-006 SHALL have port in_ready, output, 1 bit: the stage accepts an instruction; registered.
REQ-007 SHALL have ports in_pc (input, XLEN) and in_instr (input, 32): the fetched PC and instruction word.
REQ-008 SHALL have port flush, input, 1 bit: discard all held and incoming instructions (branch or jump redirect).
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the handshake towards ID.
REQ-010 SHALL have ports out_pc (output, XLEN) and out_instr (output, 32): the head entry.
REQ-011 SHALL have ports opcode (7), rs1 (5), rs2 (5), rd (5), funct3 (3) and funct7 (7), all outputs: fields of out_instr at bits [6:0], [19:15], [24:20], [11:7], [14:12] and [31:25].
REQ-012 SHALL have ports imm (output, XLEN), fmt (output, 3) and illegal (output, 1): the decoded immediate, the format code and the unknown-opcode flag.

Function
REQ-013 SHALL be a 2-entry skid buffer with a main entry and a skid entry, and SHALL have states EMPTY, ONE and TWO.
REQ-014 SHALL define a transfer as valid AND ready on the same edge, on either side.
REQ-015 SHALL make in_ready = 1 exactly when the state after the current edge is not TWO, and SHALL never drive in_ready combinationally from out_ready.
REQ-016 SHALL transition EMPTY->ONE on an input transfer.
REQ-017 SHALL, in state ONE: go to TWO on input only; go to EMPTY on output only; remain in ONE on both, with the main entry replaced by the input.
REQ-018 SHALL, in state TWO: on an output transfer, move the skid entry into main and go to ONE; no input is accepted in TWO.
REQ-019 SHALL hold out_valid = 1 exactly in states ONE and TWO, and SHALL keep out_pc and out_instr stable while out_valid=1 and out_ready=0.
REQ-020 SHALL preserve order: the skid entry is always younger than the main entry.
REQ-021 SHALL, when flush=1, go to EMPTY on the same edge, set both entries to RESET_INSTR and PC 0, and drop any input offered that cycle; flush has priority over every transfer.
REQ-022 SHALL decode fields and the immediate combinationally from out_instr, with zero added latency; the input-to-output latency is 1 cycle.
REQ-023 SHALL use the fmt encoding R=0, I=1, S=2, B=3, U=4, J=5.
REQ-024 SHALL map opcodes to fmt as follows: 0110011 -> R; 0010011, 0000011, 1100111, 1110011 and 0001111 -> I; 0100011 -> S; 1100011 -> B; 0110111 and 0010111 -> U; 1101111 -> J.
REQ-025 SHALL, for any other opcode, output illegal=1, fmt=0 and imm=0.
REQ-026 SHALL build imm per format, sign-extended from instr[31] to XLEN: I = [31:20]; S = {[31:25],[11:7]}; B = {[31],[7],[30:25],[11:8],0}; U = {[31:12], 12'b0}; J = {[31],[19:12],[20],[30:21],0}; R = 0.

Reset
REQ-027 SHALL, while rst_n=0 at an edge, set state EMPTY, out_valid=0, in_ready=0, both entries to RESET_INSTR with PC 0, and consequently opcode=7'h13, fmt=1, imm=0, illegal=0.
REQ-028 SHALL drive in_ready=1 on the first edge with rst_n=1.
REQ-029 SHALL, on reset mid-operation, discard held entries identically to flush.

Structure
REQ-030 SHALL take the opcode constants, the fmt codes and the RESET_INSTR default from the shared package riscv_pkg.
REQ-031 SHALL place decode in one sub-module, instr_decode (instruction in; fields, imm, fmt and illegal out), parameterised by XLEN.

Verification
REQ-032 SHALL cover reset: rst_n low for 2 cycles -> out_valid=0, in_ready=0, out_instr=0x00000013, imm=0; in_ready=1 one edge after release.
REQ-033 SHALL cover streaming: out_ready=1, back-to-back inputs PC 0x0,0x4,0x8 -> the same PCs appear in order, one per cycle, starting 1 cycle later.
REQ-034 SHALL cover stall and skid: out_ready=0 with 3 inputs offered -> 2 accepted, in_ready=0 after the second; raising out_ready -> both drain in order with no loss or duplication.
REQ-035 SHALL cover flush: flush in state TWO while an input is offered -> out_valid=0 next cycle, the input is dropped, out_instr=RESET_INSTR.
REQ-036 SHALL cover immediates: 0xFE010EE3 (beq) -> fmt=3, imm=-4; 0xFFF00093 (addi) -> fmt=1, imm=-1; 0x000012B7 (lui) -> fmt=4, imm=0x1000; 0x008000EF (jal) -> fmt=5, imm=8.
REQ-037 SHALL cover an illegal opcode: instr 0x0000007F -> illegal=1, fmt=0, imm=0.
